// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single-port memory, one transaction at a time.
// Optional macro MEM_ARBITER_RR_EN switches the contention policy from dmem-first to round-robin.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_imem_req,
  input  logic [31:0] i_imem_addr,
  output logic        o_imem_gnt,
  output logic        o_imem_rvalid,
  output logic [31:0] o_imem_rdata,
  output logic        o_imem_err,
  input  logic        i_dmem_req,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_gnt,
  output logic        o_dmem_rvalid,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_err,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t        state, state_next;
  logic          owner_d;
  logic [31:0]   addr, wdata;
  logic          wen;
  logic [3:0]    mask;
  logic [CW-1:0] wdog;
  logic          pick_d, grant, timeout_hit, resp, abort;

`ifdef MEM_ARBITER_RR_EN
  logic last_d;

  always_ff @(posedge i_clk) begin
    if (i_rst)      last_d <= 1'b1;
    else if (grant) last_d <= pick_d;
  end

  assign pick_d = i_dmem_req && (!i_imem_req || !last_d);
`else
  assign pick_d = i_dmem_req;
`endif

  assign grant       = (state == IDLE) && (i_imem_req || i_dmem_req);
  assign timeout_hit = (wdog == CW'(TIMEOUT - 1));
  // A response landing on the timeout cycle wins over the abort.
  assign resp        = (state == WAIT_RESP) && i_mem_rvalid;
  assign abort       = (state == WAIT_RESP) && !i_mem_rvalid && timeout_hit;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (grant) state_next = ISSUE;
      ISSUE:     if (i_mem_ready) state_next = WAIT_RESP;
      WAIT_RESP: if (resp || abort) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner_d <= 1'b0;
      addr    <= '0;
      wen     <= 1'b0;
      wdata   <= '0;
      mask    <= '0;
    end else if (grant) begin
      owner_d <= pick_d;
      addr    <= pick_d ? i_dmem_addr : i_imem_addr;
      wen     <= pick_d & i_dmem_wen;
      wdata   <= pick_d ? i_dmem_wdata : 32'h0;
      mask    <= pick_d ? i_dmem_mask : 4'hF;
    end
  end

  // Watchdog idles at zero so it is already clear on every entry to WAIT_RESP.
  always_ff @(posedge i_clk) begin
    if (i_rst)                    wdog <= '0;
    else if (state != WAIT_RESP)  wdog <= '0;
    else if (!timeout_hit)        wdog <= wdog + CW'(1);
  end

  always_comb begin
    o_imem_gnt    = 1'b0;
    o_dmem_gnt    = 1'b0;
    o_imem_rvalid = 1'b0;
    o_dmem_rvalid = 1'b0;
    o_imem_err    = 1'b0;
    o_dmem_err    = 1'b0;
    o_imem_rdata  = 32'h0;
    o_dmem_rdata  = 32'h0;
    o_mem_req     = 1'b0;
    o_mem_addr    = 32'h0;
    o_mem_wen     = 1'b0;
    o_mem_wdata   = 32'h0;
    o_mem_mask    = 4'h0;
    if (!i_rst) begin
      o_dmem_gnt  = grant && pick_d;
      o_imem_gnt  = grant && !pick_d;
      o_mem_req   = (state == ISSUE);
      o_mem_addr  = addr;
      o_mem_wen   = wen;
      o_mem_wdata = wdata;
      o_mem_mask  = mask;
      if (resp || abort) begin
        if (owner_d) begin
          o_dmem_rvalid = 1'b1;
          o_dmem_err    = abort;
          o_dmem_rdata  = (resp && !wen) ? i_mem_rdata : 32'h0;
        end else begin
          o_imem_rvalid = 1'b1;
          o_imem_err    = abort;
          o_imem_rdata  = resp ? i_mem_rdata : 32'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (default fixed-priority build, TIMEOUT=4).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, dmem_req, dmem_wen, mem_ready, mem_rvalid;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
  logic [3:0]  dmem_mask;
  logic        imem_gnt, imem_rvalid, imem_err, dmem_gnt, dmem_rvalid, dmem_err;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        mem_req, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_imem_req(imem_req), .i_imem_addr(imem_addr),
    .o_imem_gnt(imem_gnt), .o_imem_rvalid(imem_rvalid), .o_imem_rdata(imem_rdata), .o_imem_err(imem_err),
    .i_dmem_req(dmem_req), .i_dmem_addr(dmem_addr), .i_dmem_wen(dmem_wen),
    .i_dmem_wdata(dmem_wdata), .i_dmem_mask(dmem_mask),
    .o_dmem_gnt(dmem_gnt), .o_dmem_rvalid(dmem_rvalid), .o_dmem_rdata(dmem_rdata), .o_dmem_err(dmem_err),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_wen(mem_wen),
    .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ignt"}, 32'(imem_gnt), 0);
    chk({tag, "_dgnt"}, 32'(dmem_gnt), 0);
    chk({tag, "_irv"}, 32'(imem_rvalid), 0);
    chk({tag, "_drv"}, 32'(dmem_rvalid), 0);
  endtask

  initial begin
    rst = 1'b1; imem_req = 0; dmem_req = 0; dmem_wen = 0; mem_ready = 0; mem_rvalid = 0;
    imem_addr = 0; dmem_addr = 0; dmem_wdata = 0; mem_rdata = 0; dmem_mask = 0;

    // Reset state, with a request held to show no grant during reset
    @(negedge clk); imem_req = 1; imem_addr = 32'h100;
    @(negedge clk); #1;
    chk_quiet("rst");
    chk("rst_mreq", 32'(mem_req), 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mmask", 32'(mem_mask), 0);
    chk("rst_merr", 32'(imem_err | dmem_err), 0);

    // Single fetch: gnt, issue, response pass-through
    @(negedge clk); rst = 0; mem_ready = 1; #1;
    chk("f_ignt", 32'(imem_gnt), 1);
    chk("f_dgnt", 32'(dmem_gnt), 0);
    chk("f_mreq0", 32'(mem_req), 0);
    @(negedge clk); imem_req = 0; imem_addr = 32'hDEAD; #1;
    chk("f_mreq1", 32'(mem_req), 1);
    chk("f_maddr", mem_addr, 32'h100);
    chk("f_mwen", 32'(mem_wen), 0);
    chk("f_mmask", 32'(mem_mask), 32'hF);
    chk("f_igntoff", 32'(imem_gnt), 0);
    @(negedge clk); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h00100073; #1;
    chk("f_irv", 32'(imem_rvalid), 1);
    chk("f_irdata", imem_rdata, 32'h00100073);
    chk("f_ierr", 32'(imem_err), 0);
    chk("f_drv", 32'(dmem_rvalid), 0);
    chk("f_mreq2", 32'(mem_req), 0);
    @(negedge clk); mem_rvalid = 0; #1;
    chk_quiet("f_idle");

    // Contention: dmem wins all four back-to-back transactions
    imem_req = 1; imem_addr = 32'h400;
    dmem_req = 1; dmem_addr = 32'h3000; dmem_wen = 0; dmem_mask = 4'hF;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); mem_rvalid = 0; #1; end
      chk("c_dgnt", 32'(dmem_gnt), 1);
      chk("c_ignt", 32'(imem_gnt), 0);
      @(negedge clk); mem_ready = 1; #1;
      chk("c_maddr", mem_addr, 32'h3000);
      chk("c_issue_gnt", 32'(imem_gnt | dmem_gnt), 0);
      @(negedge clk); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h1000 + k; #1;
      chk("c_drv", 32'(dmem_rvalid), 1);
      chk("c_drdata", dmem_rdata, 32'h1000 + k);
      chk("c_irv", 32'(imem_rvalid), 0);
      chk("c_wait_gnt", 32'(imem_gnt | dmem_gnt), 0);
    end
    @(negedge clk); mem_rvalid = 0; imem_req = 0; dmem_req = 0; #1;

    // Store with ready delayed three cycles
    dmem_req = 1; dmem_wen = 1; dmem_addr = 32'h2000; dmem_wdata = 32'hAABBCCDD; dmem_mask = 4'b1000;
    #1;
    chk("s_dgnt", 32'(dmem_gnt), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); dmem_req = 0; dmem_wdata = 0; dmem_addr = 0; mem_ready = (i == 3); #1;
      chk("s_mreq", 32'(mem_req), 1);
      chk("s_maddr", mem_addr, 32'h2000);
      chk("s_mwen", 32'(mem_wen), 1);
      chk("s_mwdata", mem_wdata, 32'hAABBCCDD);
      chk("s_mmask", 32'(mem_mask), 32'h8);
    end
    @(negedge clk); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h12345678; #1;
    chk("s_drv", 32'(dmem_rvalid), 1);
    chk("s_derr", 32'(dmem_err), 0);
    chk("s_irv", 32'(imem_rvalid), 0);
    @(negedge clk); mem_rvalid = 0; dmem_wen = 0; #1;

    // Timeout: no response for four WAIT_RESP cycles, then a late rvalid
    imem_req = 1; imem_addr = 32'h500; mem_ready = 1; #1;
    chk("t_ignt", 32'(imem_gnt), 1);
    @(negedge clk); imem_req = 0; #1;
    chk("t_mreq", 32'(mem_req), 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); mem_ready = 0; mem_rdata = 32'hCAFE; #1;
      chk("t_irv", 32'(imem_rvalid), (i == 4) ? 1 : 0);
      chk("t_ierr", 32'(imem_err), (i == 4) ? 1 : 0);
      chk("t_irdata", imem_rdata, 0);
    end
    @(negedge clk); mem_rvalid = 1; mem_rdata = 32'hFFFF; #1;
    chk_quiet("t_late");
    chk("t_late_err", 32'(imem_err), 0);

    // Response on the timeout cycle is a normal response
    @(negedge clk); mem_rvalid = 0; imem_req = 1; imem_addr = 32'h600; mem_ready = 1; #1;
    chk("e_ignt", 32'(imem_gnt), 1);
    @(negedge clk); imem_req = 0; #1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); mem_ready = 0; #1;
      chk("e_irv", 32'(imem_rvalid), 0);
    end
    @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h5A5A0001; #1;
    chk("e_irv4", 32'(imem_rvalid), 1);
    chk("e_ierr", 32'(imem_err), 0);
    chk("e_irdata", imem_rdata, 32'h5A5A0001);
    @(negedge clk); mem_rvalid = 0; #1;

    // Reset during WAIT_RESP abandons the transaction
    dmem_req = 1; dmem_addr = 32'h6000; dmem_mask = 4'hF; mem_ready = 1; #1;
    chk("r_dgnt", 32'(dmem_gnt), 1);
    @(negedge clk); dmem_req = 0; #1;
    chk("r_mreq", 32'(mem_req), 1);
    @(negedge clk); mem_ready = 0; rst = 1; mem_rvalid = 1; mem_rdata = 32'h77; #1;
    chk_quiet("r_in");
    chk("r_in_mreq", 32'(mem_req), 0);
    chk("r_in_maddr", mem_addr, 0);
    chk("r_in_drdata", dmem_rdata, 0);
    @(negedge clk); #1;
    chk_quiet("r_in2");
    chk("r_in2_mmask", 32'(mem_mask), 0);
    @(negedge clk); rst = 0; imem_req = 1; imem_addr = 32'h700; #1;
    chk("r_post_ignt", 32'(imem_gnt), 1);
    chk("r_post_drv", 32'(dmem_rvalid), 0);
    chk("r_post_irv", 32'(imem_rvalid), 0);
    @(negedge clk); imem_req = 0; mem_rvalid = 0; #1;
    chk("r_post_maddr", mem_addr, 32'h700);
    chk("r_post_mreq", 32'(mem_req), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles to wait in WAIT_RESP before aborting a transaction.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports i_imem_req (in, 1), i_imem_addr (in, 32): instruction fetch request; fetches are always reads.
REQ-005 SHALL have ports o_imem_gnt (out, 1), o_imem_rvalid (out, 1), o_imem_rdata (out, 32), o_imem_err (out, 1): fetch grant and response.
REQ-006 SHALL have ports i_dmem_req (in, 1), i_dmem_addr (in, 32), i_dmem_wen (in, 1), i_dmem_wdata (in, 32), i_dmem_mask (in, 4): data load/store request.
REQ-007 SHALL have ports o_dmem_gnt (out, 1), o_dmem_rvalid (out, 1), o_dmem_rdata (out, 32), o_dmem_err (out, 1): data grant and response.
REQ-008 SHALL have ports o_mem_req (out, 1), o_mem_addr (out, 32), o_mem_wen (out, 1), o_mem_wdata (out, 32), o_mem_mask (out, 4): request to the shared memory.
REQ-009 SHALL have ports i_mem_ready (in, 1), i_mem_rvalid (in, 1), i_mem_rdata (in, 32): memory accept and response; writes are also acknowledged through i_mem_rvalid.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, ISSUE, WAIT_RESP.
REQ-011 In IDLE with at least one request: SHALL select one requester, pulse that requester's o_*_gnt for one cycle, latch its addr, wen, wdata and mask, and go to ISSUE next cycle.
REQ-012 Fetch requests SHALL be issued with o_mem_wen=0 and o_mem_mask=4'b1111.
REQ-013 When both requesters are active in the same IDLE cycle, dmem SHALL win (fixed priority), unless REQ-027 applies.
REQ-014 In ISSUE: o_mem_req=1 and the latched fields SHALL stay stable until the cycle in which i_mem_ready=1; the FSM then goes to WAIT_RESP.
REQ-015 In WAIT_RESP: i_mem_rvalid=1 SHALL cause, in the same cycle, o_*_rvalid=1 for the owner with o_*_rdata=i_mem_rdata; the FSM returns to IDLE next cycle.
REQ-016 A read response SHALL be combinational pass-through with 0 added cycles; i_mem_rdata is undefined for writes and SHALL NOT be interpreted.
REQ-017 At most one transaction SHALL be outstanding; no grant is issued outside IDLE.
REQ-018 i_mem_rvalid outside WAIT_RESP SHALL be ignored.
REQ-019 A requester SHALL hold req, addr and data until it sees its gnt; changes after gnt SHALL NOT affect the latched transaction.
REQ-020 Minimum transaction cost: grant (IDLE) + 1 ISSUE + 1 WAIT_RESP = 3 cycles; the next grant comes in the cycle after the response.
REQ-021 Watchdog: a counter SHALL clear on entry to WAIT_RESP and increment each WAIT_RESP cycle.
REQ-022 If the counter reaches TIMEOUT without i_mem_rvalid, the arbiter SHALL pulse o_*_rvalid and o_*_err for one cycle to the owner, with rdata=0, and return to IDLE.
REQ-023 A late i_mem_rvalid after a timeout SHALL be dropped per REQ-018.
REQ-024 i_mem_rvalid arriving in the same cycle the counter reaches TIMEOUT SHALL be treated as a normal response, with err=0.

Reset
REQ-025 While i_rst=1 the arbiter SHALL hold or force: state=IDLE; o_mem_req, o_mem_wen and all gnt/rvalid/err = 0; o_mem_addr, o_mem_wdata, rdata = 0; o_mem_mask=0; watchdog=0; round-robin pointer=dmem-last.
REQ-026 Reset asserted mid-transaction SHALL abandon it with no response pulse; the first grant is possible in the first cycle after i_rst deasserts.

Configuration
REQ-027 Macro MEM_ARBITER_RR_EN defined: when both request in IDLE, the requester not granted most recently SHALL win, and the pointer updates on every grant.
REQ-028 Macro undefined: fixed dmem-first priority (REQ-013) applies and no pointer register is built.

Verification
REQ-029 Single fetch: imem_req, addr=0x100; i_mem_ready=1 immediately; rvalid with rdata=0x00100073 two cycles later -> gnt at cycle 0, o_mem_req at cycle 1, o_imem_rvalid with rdata=0x00100073 at cycle 2, no dmem activity.
REQ-030 Contention, fixed priority: both request for 4 transactions -> dmem is granted every time, with no imem grant while dmem_req is held; under MEM_ARBITER_RR_EN the grants alternate d,i,d,i.
REQ-031 Store: dmem wen=1, addr=0x2000, wdata=0xAABBCCDD, mask=4'b1000; i_mem_ready delayed 3 cycles -> o_mem_* stable across all 4 ISSUE cycles, and o_dmem_rvalid=1 with err=0 on the ack.
REQ-032 Timeout: TIMEOUT=4, memory never responds -> o_imem_rvalid=1, o_imem_err=1, rdata=0 on the 4th WAIT_RESP cycle; a later spurious i_mem_rvalid produces no output.
REQ-033 Reset mid-transaction: i_rst in WAIT_RESP, then rvalid after reset -> no rvalid output, all outputs 0 during reset, and a new request is granted the cycle after reset drops.
